// File: rtl/mdu_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
// Accumulate ops (MADD/MADDU/MSUB/MSUBU) are recognised only when MDU_MADD_EN is defined.
package mdu_pkg;

  typedef logic [3:0] mdu_op_t;

  localparam mdu_op_t MDU_MULT  = 4'd0;
  localparam mdu_op_t MDU_MULTU = 4'd1;
  localparam mdu_op_t MDU_DIV   = 4'd2;
  localparam mdu_op_t MDU_DIVU  = 4'd3;
  localparam mdu_op_t MDU_MTHI  = 4'd4;
  localparam mdu_op_t MDU_MTLO  = 4'd5;
  localparam mdu_op_t MDU_MADD  = 4'd8;
  localparam mdu_op_t MDU_MADDU = 4'd9;
  localparam mdu_op_t MDU_MSUB  = 4'd10;
  localparam mdu_op_t MDU_MSUBU = 4'd11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  // Codes that the unit acts on; everything else is a silent no-op.
  function automatic logic is_mdu_op(input mdu_op_t op);
    case (op)
      MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO: return 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // Multiply variants that treat both operands as two's complement.
  function automatic logic mul_is_signed(input mdu_op_t op);
    return (op == MDU_MULT) || (op == MDU_MADD) || (op == MDU_MSUB);
  endfunction

endpackage

// File: rtl/mdu_hilo_if.sv
// Request/result bundle between the EX stage and the HI/LO unit.
interface mdu_hilo_if #(parameter int WIDTH = 32);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, hi, lo);
  modport slave  (input start, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/mdu_div_core.sv
// One restoring-division step per cycle on unsigned magnitudes.
// i_valid loads a new problem, i_step advances one bit, o_done rises after the step flagged i_last.
module mdu_div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_step,
  input  logic             i_last,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quo,
  output logic [WIDTH-1:0] o_rem
);

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic             r_done;

  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  // Shift the next dividend bit into the partial remainder and try the subtract.
  always_comb begin
    w_trial = {r_rem, r_quo[WIDTH-1]};
    w_ge    = (w_trial >= {1'b0, r_dvs});
    w_diff  = w_trial[WIDTH-1:0] - r_dvs;
  end

  // Load on a new request, otherwise commit one step per i_step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvs  <= '0;
      r_done <= 1'b0;
    end else if (i_valid) begin
      r_rem  <= '0;
      r_quo  <= i_dividend;
      r_dvs  <= i_divisor;
      r_done <= 1'b0;
    end else if (i_step) begin
      r_rem  <= w_ge ? w_diff : w_trial[WIDTH-1:0];
      r_quo  <= {r_quo[WIDTH-2:0], w_ge};
      if (i_last) r_done <= 1'b1;
    end
  end

  assign o_done = r_done;
  assign o_quo  = r_quo;
  assign o_rem  = r_rem;

endmodule

// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO pair.
// Optional feature macro: MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU accumulate ops.
//
// state  | meaning
// S_IDLE | ready; accepts start, MTHI/MTLO complete here
// S_MUL  | multiply in flight, commit when counter hits MUL_LAT-1
// S_DIV  | one restoring step per cycle, WIDTH steps
// S_FIX  | sign fix-up and commit of quotient/remainder
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic     clk,
  input  logic     reset,
  mdu_hilo_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] MUL_TC = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_TC = CW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_ma;
  logic [WIDTH-1:0] r_mb;
  logic             r_msigned;
`ifdef MDU_MADD_EN
  mdu_op_t          r_mop;
`endif
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz;

  logic             w_accept;
  logic             w_is_mul;
  logic             w_is_div;
  logic             w_div_signed;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;
  logic             w_div_done;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_r;
  logic [2*WIDTH-1:0] w_xa;
  logic [2*WIDTH-1:0] w_xb;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_mul_res;

  assign w_accept = bus.start && !r_busy && (r_state == S_IDLE) && is_mdu_op(bus.op);

`ifdef MDU_MADD_EN
  assign w_is_mul = (bus.op == MDU_MULT) || (bus.op == MDU_MULTU) ||
                    (bus.op == MDU_MADD) || (bus.op == MDU_MADDU) ||
                    (bus.op == MDU_MSUB) || (bus.op == MDU_MSUBU);
`else
  assign w_is_mul = (bus.op == MDU_MULT) || (bus.op == MDU_MULTU);
`endif
  assign w_is_div     = (bus.op == MDU_DIV) || (bus.op == MDU_DIVU);
  assign w_div_signed = (bus.op == MDU_DIV);

  // Divider works on magnitudes; MIN_INT maps to 2^(WIDTH-1), which still fits unsigned.
  assign w_mag_a = (w_div_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign w_mag_b = (w_div_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  mdu_div_core #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .reset      (reset),
    .i_valid    (w_accept && w_is_div),
    .i_dividend (w_mag_a),
    .i_divisor  (w_mag_b),
    .i_step     (r_state == S_DIV),
    .i_last     (r_cnt == DIV_TC),
    .o_done     (w_div_done),
    .o_quo      (w_quo),
    .o_rem      (w_rem)
  );

  // Restore signs: quotient negative on differing signs, remainder follows the dividend.
  assign w_q = r_neg_q ? -w_quo : w_quo;
  assign w_r = r_neg_r ? -w_rem : w_rem;

  // Full 2*WIDTH product from the latched operands, plus optional accumulate.
  always_comb begin
    w_xa   = r_msigned ? {{WIDTH{r_ma[WIDTH-1]}}, r_ma} : {{WIDTH{1'b0}}, r_ma};
    w_xb   = r_msigned ? {{WIDTH{r_mb[WIDTH-1]}}, r_mb} : {{WIDTH{1'b0}}, r_mb};
    w_prod = w_xa * w_xb;
`ifdef MDU_MADD_EN
    case (r_mop)
      MDU_MADD, MDU_MADDU: w_mul_res = {r_hi, r_lo} + w_prod;
      MDU_MSUB, MDU_MSUBU: w_mul_res = {r_hi, r_lo} - w_prod;
      default:             w_mul_res = w_prod;
    endcase
`else
    w_mul_res = w_prod;
`endif
  end

  // Sequencing FSM with terminal-count compare; owns HI/LO and all commits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_ma      <= '0;
      r_mb      <= '0;
      r_msigned <= 1'b0;
`ifdef MDU_MADD_EN
      r_mop     <= MDU_MULT;
`endif
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_dz      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt <= '0;
            if (w_is_mul) begin
              r_ma      <= bus.a;
              r_mb      <= bus.b;
              r_msigned <= mul_is_signed(bus.op);
`ifdef MDU_MADD_EN
              r_mop     <= bus.op;
`endif
              r_state   <= S_MUL;
              r_busy    <= 1'b1;
            end else if (w_is_div) begin
              r_neg_q <= w_div_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
              r_neg_r <= w_div_signed && bus.a[WIDTH-1];
              r_dz    <= (bus.b == '0);
              r_state <= S_DIV;
              r_busy  <= 1'b1;
            end else if (bus.op == MDU_MTHI) begin
              r_hi <= bus.a;
            end else if (bus.op == MDU_MTLO) begin
              r_lo <= bus.a;
            end
          end
        end
        S_MUL: begin
          if (r_cnt == MUL_TC) begin
            {r_hi, r_lo} <= w_mul_res;
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DIV: begin
          if (r_cnt == DIV_TC) begin
            r_state <= S_FIX;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_FIX: begin
          if (!r_dz && w_div_done) begin
            r_lo <= w_q;
            r_hi <= w_r;
          end
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed plus randomized bench for mdu_hilo (WIDTH=32, MUL_LAT=5) against an arithmetic model.
module tb_mdu_hilo;

  localparam int W       = 32;
  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = W + 1;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mdu_hilo_if #(.WIDTH(W)) bus ();

  mdu_hilo #(.WIDTH(W), .MUL_LAT(MUL_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sp;
    if (sgn) begin
      sp = longint'($signed(a)) * longint'($signed(b));
      return 64'(sp);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Architectural effect of one op on the model HI/LO; returns expected busy cycles.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int lat);
    longint q, r;
    logic [63:0] acc;
    lat = 0;
    case (op)
      4'd0, 4'd1: begin
        lat = MUL_LAT;
        {m_hi, m_lo} = ref_prod(op == 4'd0, a, b);
      end
      4'd2, 4'd3: begin
        lat = DIV_LAT;
        if (b != 0) begin
          if (op == 4'd2) begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
          end else begin
            q = longint'({32'b0, a}) / longint'({32'b0, b});
            r = longint'({32'b0, a}) % longint'({32'b0, b});
          end
          m_lo = q[31:0];
          m_hi = r[31:0];
        end
      end
      4'd4: m_hi = a;
      4'd5: m_lo = a;
`ifdef MDU_MADD_EN
      4'd8, 4'd9, 4'd10, 4'd11: begin
        lat = MUL_LAT;
        acc = {m_hi, m_lo};
        if (op < 4'd10) acc = acc + ref_prod(op == 4'd8, a, b);
        else            acc = acc - ref_prod(op == 4'd10, a, b);
        {m_hi, m_lo} = acc;
      end
`endif
      default: ;
    endcase
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int lat, n;
    logic [31:0] old_hi, old_lo;
    logic held;
    old_hi = m_hi;
    old_lo = m_lo;
    model(op, a, b, lat);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
    n = 0;
    held = 1'b1;
    while (bus.busy && n < 200) begin
      if (bus.hi !== old_hi || bus.lo !== old_lo) held = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " busy_cycles"}, 32'(n), 32'(lat));
    chk({tag, " hilo_held_while_busy"}, {31'b0, held}, 32'd1);
    chk({tag, " hi"}, bus.hi, m_hi);
    chk({tag, " lo"}, bus.lo, m_lo);
  endtask

  initial begin
    int lat, n;
    logic [3:0] rop;
    logic [31:0] ra, rb;
    errors = 0;
    checks = 0;
    m_hi = '0;
    m_lo = '0;
    reset = 1'b0;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;

    #12;
    chk("reset busy", {31'b0, bus.busy}, 32'd0);
    chk("reset hi", bus.hi, 32'd0);
    chk("reset lo", bus.lo, 32'd0);
    #10 reset = 1'b1;

    // Multiply
    run_op("MULT -1*2", 4'd0, 32'hFFFF_FFFF, 32'd2);
    chk("MULT -1*2 hi const", bus.hi, 32'hFFFF_FFFF);
    chk("MULT -1*2 lo const", bus.lo, 32'hFFFF_FFFE);
    run_op("MULTU ffffffff*2", 4'd1, 32'hFFFF_FFFF, 32'd2);
    chk("MULTU hi const", bus.hi, 32'h0000_0001);

    // Divide
    run_op("DIV -7/2", 4'd2, 32'hFFFF_FFF9, 32'd2);
    chk("DIV -7/2 lo const", bus.lo, 32'hFFFF_FFFD);
    chk("DIV -7/2 hi const", bus.hi, 32'hFFFF_FFFF);
    run_op("DIVU 7/2", 4'd3, 32'd7, 32'd2);
    run_op("DIV min/-1", 4'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("DIV min/-1 lo const", bus.lo, 32'h8000_0000);
    run_op("DIV 7/-2", 4'd2, 32'd7, 32'hFFFF_FFFE);
    run_op("DIVU big", 4'd3, 32'hFFFF_FFFF, 32'h0001_0001);

    // Divide by zero leaves HI/LO alone
    run_op("MTHI aa", 4'd4, 32'h0000_00AA, 32'd0);
    run_op("MTLO bb", 4'd5, 32'h0000_00BB, 32'd0);
    run_op("DIV 5/0", 4'd2, 32'd5, 32'd0);
    chk("DIV 5/0 hi const", bus.hi, 32'h0000_00AA);
    run_op("MTHI 1234", 4'd4, 32'h0000_1234, 32'd0);

    // MTLO while a MULT is busy must be ignored
    model(4'd0, 32'd3, 32'd5, lat);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 4'd0; bus.a = 32'd3; bus.b = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 4'd5; bus.a = 32'h0000_DEAD; bus.b = 32'd0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 1;
    while (bus.busy && n < 200) begin @(posedge clk); #1; n++; end
    chk("MULT+MTLO busy_cycles", 32'(n), 32'(lat));
    chk("MULT+MTLO lo", bus.lo, m_lo);
    chk("MULT+MTLO hi", bus.hi, m_hi);

    // Accumulate ops (no-ops when the feature is absent)
    run_op("MTHI 0", 4'd4, 32'd0, 32'd0);
    run_op("MTLO 5", 4'd5, 32'd5, 32'd0);
    run_op("op8 3,4", 4'd8, 32'd3, 32'd4);
    run_op("op11 1,18", 4'd11, 32'd1, 32'd18);
`ifdef MDU_MADD_EN
    chk("MSUBU wrap lo const", bus.lo, 32'hFFFF_FFFF);
`else
    chk("op8 noop lo const", bus.lo, 32'd5);
`endif
    run_op("op7 noop", 4'd7, 32'h1111_1111, 32'd3);
    run_op("op15 noop", 4'd15, 32'h2222_2222, 32'd3);

    // Random mix
    for (int i = 0; i < 40; i++) begin
      rop = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 5)) : 4'($urandom_range(6, 15));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 :
            ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if ($urandom_range(0, 3) == 0) rb = -rb;
      run_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb);
    end

    // Reset in the middle of a divide aborts it
    run_op("MTHI 55", 4'd4, 32'h55, 32'd0);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 4'd2; bus.a = 32'd100; bus.b = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort busy", {31'b0, bus.busy}, 32'd0);
    chk("abort hi", bus.hi, 32'd0);
    chk("abort lo", bus.lo, 32'd0);
    #2;
    @(negedge clk);
    reset = 1'b1;
    m_hi = '0;
    m_lo = '0;
    repeat (40) @(posedge clk);
    #1;
    chk("post-abort busy", {31'b0, bus.busy}, 32'd0);
    chk("post-abort hi", bus.hi, 32'd0);
    chk("post-abort lo", bus.lo, 32'd0);
    run_op("post-abort MULTU", 4'd1, 32'd6, 32'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
